// File: rtl/ps2_keyboard_events.sv
// rtl/ps2_keyboard_events.sv - PS/2 set-2 receiver decoding the byte stream into buffered key events.
module ps2_keyboard_events #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    output logic         ev_valid,
    input  logic         ev_ready,
    output logic [9:0]   ev_data,
    output logic [7:0]   current_scan_code,
    output logic         current_make_break,
    output logic [511:0] key_state,
    output logic         frame_err,
    output logic         overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk, filt_prev;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] wd;
    logic          byte_ok, byte_bad, tmo_strb;
    logic [7:0]    rx_byte;

    logic          ext_flag, brk_flag;
    logic [2:0]    skip_cnt;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, pop, is_event, do_push;
    logic [9:0]    new_ev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            dat_s1    <= 1'b1;
            dat_s2    <= 1'b1;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            clk_s1    <= ps2_clk;
            clk_s2    <= clk_s1;
            dat_s1    <= ps2_data;
            dat_s2    <= dat_s1;
            filt_prev <= filt_clk;
            // A new level is only accepted after it has differed from the filtered value long enough.
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_CYCLES - 1)) begin
                filt_clk <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign fall = filt_prev & ~filt_clk;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            wd       <= '0;
            byte_ok  <= 1'b0;
            byte_bad <= 1'b0;
            tmo_strb <= 1'b0;
            rx_byte  <= '0;
        end else begin
            byte_ok  <= 1'b0;
            byte_bad <= 1'b0;
            tmo_strb <= 1'b0;
            if (state != IDLE && !fall && wd == TW'(TIMEOUT_CYCLES - 1)) begin
                state    <= IDLE;
                tmo_strb <= 1'b1;
                wd       <= '0;
            end else if (fall) begin
                wd <= '0;
                case (state)
                    IDLE: if (!dat_s2) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= dat_s2;
                        state   <= STOP;
                    end
                    STOP: begin
                        state   <= IDLE;
                        rx_byte <= shreg;
                        if (dat_s2 && ^{shreg, par_bit}) byte_ok  <= 1'b1;
                        else                             byte_bad <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                wd <= wd + TW'(1);
            end
        end
    end

    assign ev_valid = (wr_ptr != rd_ptr);
    assign ev_data  = ev_valid ? mem[rd_ptr[AW-1:0]] : 10'd0;
    assign full     = ((wr_ptr - rd_ptr) == PW'(FIFO_DEPTH));
    assign pop      = ev_valid & ev_ready;
    assign is_event = byte_ok && (skip_cnt == 3'd0) &&
                      (rx_byte != 8'hE0) && (rx_byte != 8'hF0) && (rx_byte != 8'hE1);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign do_push  = is_event && (!full || pop);
    assign new_ev   = {ext_flag, ~brk_flag, rx_byte};

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= new_ev;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_flag           <= 1'b0;
            brk_flag           <= 1'b0;
            skip_cnt           <= '0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            current_scan_code  <= '0;
            current_make_break <= 1'b0;
            key_state          <= '0;
            frame_err          <= 1'b0;
            overflow           <= 1'b0;
        end else begin
            frame_err <= byte_bad | tmo_strb;
            overflow  <= is_event & ~do_push;
            wr_ptr    <= wr_ptr + {{AW{1'b0}}, do_push};
            rd_ptr    <= rd_ptr + {{AW{1'b0}}, pop};
            if (byte_bad || tmo_strb) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
                skip_cnt <= '0;
            end else if (byte_ok) begin
                if (skip_cnt != 3'd0) begin
                    skip_cnt <= skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) begin
                        ext_flag <= 1'b0;
                        brk_flag <= 1'b0;
                    end
                end else begin
                    case (rx_byte)
                        8'hE0: ext_flag <= 1'b1;
                        8'hF0: brk_flag <= 1'b1;
                        8'hE1: skip_cnt <= 3'd7;
                        default: begin
                            current_scan_code             <= rx_byte;
                            current_make_break            <= ~brk_flag;
                            key_state[{ext_flag, rx_byte}] <= ~brk_flag;
                            ext_flag                      <= 1'b0;
                            brk_flag                      <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_events.sv
// tb/tb_ps2_keyboard_events.sv - scoreboard bench for ps2_keyboard_events with a byte-level reference model.
module tb_ps2_keyboard_events;
    localparam int DEPTH = 8;
    localparam int FILT  = 4;
    localparam int TMO   = 500;
    localparam int HALF  = 20;

    logic         clk = 1'b0;
    logic         rst, ps2_clk, ps2_data, ev_ready;
    logic         ev_valid, current_make_break, frame_err, overflow;
    logic [9:0]   ev_data;
    logic [7:0]   current_scan_code;
    logic [511:0] key_state;

    ps2_keyboard_events #(.FIFO_DEPTH(DEPTH), .FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
        .current_scan_code(current_scan_code), .current_make_break(current_make_break),
        .key_state(key_state), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    logic [9:0] expq[$];
    int exp_err = 0, seen_err = 0, exp_ovf = 0, seen_ovf = 0;
    bit m_ext = 0, m_brk = 0;
    int m_skip = 0;
    logic [511:0] m_ks = '0;
    logic [7:0] m_code = 8'h00;
    logic m_make = 1'b0;
    logic prev_fe = 1'b0, prev_ov = 1'b0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decoder: applies the prefix / skip rules to each good byte.
    task automatic model_byte(input logic [7:0] b);
        logic [9:0] ev;
        if (m_skip > 0) begin
            m_skip--;
            if (m_skip == 0) begin m_ext = 0; m_brk = 0; end
        end else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE1) m_skip = 7;
        else begin
            ev = {m_ext, ~m_brk, b};
            m_code = b;
            m_make = ~m_brk;
            m_ks[{m_ext, b}] = ~m_brk;
            if (expq.size() >= DEPTH) exp_ovf++;
            else expq.push_back(ev);
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic model_err();
        exp_err++;
        m_ext = 0; m_brk = 0; m_skip = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] bits;
        logic p;
        p = ~^b;
        if (bad_par) p = ~p;
        bits = {1'b1, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (HALF) tick();
            ps2_clk = 1'b0;
            repeat (HALF) tick();
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (3 * HALF) tick();
    endtask

    task automatic check_state(input string tag);
        check({tag, ".code"}, current_scan_code, m_code);
        check({tag, ".make"}, current_make_break, m_make);
        check({tag, ".keys"}, key_state, m_ks);
        check({tag, ".errs"}, seen_err, exp_err);
        check({tag, ".ovf"}, seen_ovf, exp_ovf);
    endtask

    task automatic good(input logic [7:0] b);
        model_byte(b);
        send_frame(b, 1'b0, 11);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (ev_valid && ev_ready) begin
                if (expq.size() == 0) check("unexpected_event", ev_data, 10'h3FF);
                else check("ev_data", ev_data, expq.pop_front());
            end
            if (frame_err) begin
                seen_err++;
                if (prev_fe) check("frame_err_width", 2, 1);
            end
            if (overflow) begin
                seen_ovf++;
                if (prev_ov) check("overflow_width", 2, 1);
            end
        end
        prev_fe = frame_err;
        prev_ov = overflow;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] b;
        bit bad;
        logic [7:0] pause_seq [8];
        logic [7:0] ovf_seq [9];
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        ovf_seq   = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; ev_ready = 1'b1;
        repeat (5) tick();
        check("rst.ev_valid", ev_valid, 0);
        check("rst.ev_data", ev_data, 0);
        check("rst.frame_err", frame_err, 0);
        check("rst.overflow", overflow, 0);
        check_state("rst");
        rst = 1'b1;
        repeat (5) tick();

        good(8'h1C);                 check_state("make1C");
        check("key01C_set", key_state[9'h01C], 1);
        good(8'hF0); good(8'h1C);    check_state("break1C");
        good(8'hE0); good(8'hF0); good(8'h75); check_state("ext_break75");

        model_err();
        send_frame(8'h1C, 1'b1, 11); check_state("bad_parity");
        good(8'h1C);                 check_state("after_parity");

        send_frame(8'h29, 1'b0, 5);
        repeat (TMO + 50) tick();
        model_err();                 check_state("timeout");
        good(8'h29);                 check_state("after_timeout");

        for (int i = 0; i < 8; i++) good(pause_seq[i]);
        good(8'h1C);                 check_state("pause");

        ev_ready = 1'b0;
        for (int i = 0; i < 9; i++) good(ovf_seq[i]);
        check_state("overflow");
        check("fifo_full_valid", ev_valid, 1);
        ev_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        check("drained", expq.size(), 0);
        check("drained_valid", ev_valid, 0);

        for (int n = 0; n < 40; n++) begin
            b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 9) == 0);
            if (bad) begin
                model_err();
                send_frame(b, 1'b1, 11);
            end else begin
                good(b);
            end
            check_state("random");
        end
        repeat (20) tick();
        check("final_queue_empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
